// File: rtl/ar_rob_pkg.sv
// Shared types and defaults for the read-path UID allocator and its consumers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ar_rob_pkg;

  localparam int DEF_ID_WIDTH  = 4;
  localparam int DEF_UID_WIDTH = 4;

  typedef logic [DEF_ID_WIDTH-1:0]  axi_id_t;
  typedef logic [DEF_UID_WIDTH-1:0] uid_t;

  // Allocator FSM encoding
  localparam logic [0:0] ALLOC_IDLE  = 1'b0;
  localparam logic [0:0] ALLOC_GRANT = 1'b1;

endpackage

// File: rtl/ar_uid_allocator_if.sv
// Bundle of allocation, release and lookup signals between ordering units and the UID pool.
// Latency: n/a (wiring only).
// Backpressure: grant is held until the requester acks or withdraws its request.
interface ar_uid_allocator_if #(
  parameter int NUM_REQ   = 2,
  parameter int ID_WIDTH  = ar_rob_pkg::DEF_ID_WIDTH,
  parameter int UID_WIDTH = ar_rob_pkg::DEF_UID_WIDTH
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*ID_WIDTH-1:0] req_id;
  logic [NUM_REQ-1:0]          req_ack;
  logic [NUM_REQ-1:0]          gnt;
  logic [UID_WIDTH-1:0]        gnt_uid;
  logic                        rel_valid;
  logic [UID_WIDTH-1:0]        rel_uid;
  logic [UID_WIDTH-1:0]        lookup_uid;
  logic [ID_WIDTH-1:0]         lookup_id;
  logic [UID_WIDTH:0]          free_count;
  logic                        err_rel;

  modport master (
    output req_valid, req_id, req_ack, rel_valid, rel_uid, lookup_uid,
    input  gnt, gnt_uid, lookup_id, free_count, err_rel
  );

  modport slave (
    input  req_valid, req_id, req_ack, rel_valid, rel_uid, lookup_uid,
    output gnt, gnt_uid, lookup_id, free_count, err_rel
  );
endinterface

// File: rtl/ar_uid_allocator_rr_arbiter.sv
// One-hot round-robin picker: first asserted request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; caller decides when the pick is consumed.
module ar_uid_allocator_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan offsets from the far end so the nearest candidate to ptr wins last
  always_comb begin : pick
    logic [IW-1:0] c;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = '0;
    for (int off = N - 1; off >= 0; off--) begin
      c = IW'((int'(ptr) + off) % N);
      if (req[c]) begin
        gnt    = '0;
        gnt[c] = 1'b1;
        idx    = c;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ar_uid_allocator.sv
// Shared UID pool: round-robin grant of the lowest free UID, commit on ack, free on release.
// Latency: 1 cycle req_valid->gnt; at most one grant per 2 cycles; optional AR_UID_ID_LIMIT_EN caps per-ID outstanding.
// Backpressure: grant held stable until req_ack commits it or req_valid drops (reservation returned).
module ar_uid_allocator
  import ar_rob_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int UID_WIDTH  = DEF_UID_WIDTH,
  parameter int MAX_PER_ID = 4
) (
  input  logic clk,
  input  logic rst,
  ar_uid_allocator_if.slave bus
);

  localparam int NUM_UID = 2 ** UID_WIDTH;
  localparam int SEL_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [0:0]           state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [UID_WIDTH-1:0] gnt_uid_q, gnt_uid_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_UID-1:0]   free_q, free_d;
  logic [NUM_UID-1:0]   busy_q, busy_d;
  logic [ID_WIDTH-1:0]  table_q [NUM_UID];
  logic [ID_WIDTH-1:0]  table_d [NUM_UID];
  logic [UID_WIDTH:0]   free_count_q, free_count_d;
  logic                 err_rel_q, err_rel_d;

  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [SEL_W-1:0]     arb_idx;
  logic                 arb_any;
  logic [UID_WIDTH-1:0] free_idx;
  logic [ID_WIDTH-1:0]  sel_id;
  logic                 reserve, commit, abandon, rel_ok;

  assign sel_id  = bus.req_id[sel_q*ID_WIDTH +: ID_WIDTH];
  assign reserve = (state_q == ALLOC_IDLE) && arb_any;
  assign commit  = (state_q == ALLOC_GRANT) && bus.req_ack[sel_q];
  assign abandon = (state_q == ALLOC_GRANT) && !bus.req_ack[sel_q] && !bus.req_valid[sel_q];
  assign rel_ok  = bus.rel_valid && busy_q[bus.rel_uid];

`ifdef AR_UID_ID_LIMIT_EN
  localparam int NUM_ID = 2 ** ID_WIDTH;
  localparam int CNT_W  = $clog2(MAX_PER_ID + 1);

  logic [CNT_W-1:0]    cnt_q [NUM_ID];
  logic [CNT_W-1:0]    cnt_d [NUM_ID];
  logic [ID_WIDTH-1:0] dec_id;

  assign dec_id = table_q[bus.rel_uid];

  // Requesters need a free UID and an original ID below its outstanding cap
  always_comb begin
    elig = bus.req_valid & {NUM_REQ{|free_q}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cnt_q[bus.req_id[i*ID_WIDTH +: ID_WIDTH]] == CNT_W'(MAX_PER_ID)) elig[i] = 1'b0;
    end
  end

  // Per-ID outstanding count: up on commit, down on valid release, net zero if both hit one ID
  always_comb begin
    for (int k = 0; k < NUM_ID; k++) begin
      cnt_d[k] = cnt_q[k];
      if (commit && sel_id == ID_WIDTH'(k) && !(rel_ok && dec_id == ID_WIDTH'(k)))
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      else if (rel_ok && dec_id == ID_WIDTH'(k) && !(commit && sel_id == ID_WIDTH'(k)))
        cnt_d[k] = cnt_q[k] - CNT_W'(1);
    end
  end

  // Outstanding counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_ID; k++) cnt_q[k] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unused_max_per_id = MAX_PER_ID;

  // Any valid requester is eligible while the pool is not empty
  always_comb begin
    elig = bus.req_valid & {NUM_REQ{|free_q}};
  end
`endif

  ar_uid_allocator_rr_arbiter #(.N(NUM_REQ), .IW(SEL_W)) u_arb (
    .req (elig),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Lowest-index free UID
  always_comb begin
    free_idx = '0;
    for (int u = NUM_UID - 1; u >= 0; u--) begin
      if (free_q[u]) free_idx = UID_WIDTH'(u);
    end
  end

  // Grant FSM, pool state, mapping table and release handling
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_uid_d = gnt_uid_q;
    sel_d     = sel_q;
    rr_ptr_d  = rr_ptr_q;
    free_d    = free_q;
    busy_d    = busy_q;
    table_d   = table_q;
    err_rel_d = err_rel_q;
    case (state_q)
      ALLOC_IDLE: begin
        if (arb_any) begin
          state_d          = ALLOC_GRANT;
          gnt_d            = arb_gnt;
          gnt_uid_d        = free_idx;
          sel_d            = arb_idx;
          free_d[free_idx] = 1'b0;
        end
      end
      default: begin
        if (commit) begin
          busy_d[gnt_uid_q]  = 1'b1;
          table_d[gnt_uid_q] = sel_id;
          rr_ptr_d = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + SEL_W'(1);
          state_d  = ALLOC_IDLE;
          gnt_d    = '0;
        end else if (abandon) begin
          free_d[gnt_uid_q] = 1'b1;
          state_d = ALLOC_IDLE;
          gnt_d   = '0;
        end
      end
    endcase
    // A busy UID can never be the reserved one, so release and commit never collide
    if (bus.rel_valid) begin
      if (rel_ok) begin
        busy_d[bus.rel_uid] = 1'b0;
        free_d[bus.rel_uid] = 1'b1;
      end else begin
        err_rel_d = 1'b1;
      end
    end
    free_count_d = free_count_q + (UID_WIDTH+1)'(rel_ok) + (UID_WIDTH+1)'(abandon)
                 - (UID_WIDTH+1)'(reserve);
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ALLOC_IDLE;
      gnt_q        <= '0;
      gnt_uid_q    <= '0;
      sel_q        <= '0;
      rr_ptr_q     <= '0;
      free_q       <= '1;
      busy_q       <= '0;
      free_count_q <= (UID_WIDTH+1)'(NUM_UID);
      err_rel_q    <= 1'b0;
      for (int u = 0; u < NUM_UID; u++) table_q[u] <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gnt_uid_q    <= gnt_uid_d;
      sel_q        <= sel_d;
      rr_ptr_q     <= rr_ptr_d;
      free_q       <= free_d;
      busy_q       <= busy_d;
      free_count_q <= free_count_d;
      err_rel_q    <= err_rel_d;
      table_q      <= table_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.gnt_uid    = gnt_uid_q;
  assign bus.lookup_id  = table_q[bus.lookup_uid];
  assign bus.free_count = free_count_q;
  assign bus.err_rel    = err_rel_q;

endmodule

// File: tb/tb_ar_uid_allocator.sv
// Bench for ar_uid_allocator: directed scenarios plus randomized traffic against a UID-status model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ar_uid_allocator;

  localparam int NR  = 2;
  localparam int IW  = 4;
  localparam int UW  = 4;
  localparam int NU  = 16;
  localparam int MPI = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ar_uid_allocator_if #(.NUM_REQ(NR), .ID_WIDTH(IW), .UID_WIDTH(UW)) bus ();

  ar_uid_allocator #(.NUM_REQ(NR), .ID_WIDTH(IW), .UID_WIDTH(UW), .MAX_PER_ID(MPI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: per-UID status 0=free 1=reserved 2=busy, stored IDs, current grant
  int st  [NU];
  int tbl [NU];
  int cnt [1 << IW];
  int m_rr;
  bit m_gr;
  int m_sel;
  int m_uid;
  bit m_err;

  function automatic int req_id_of(int r);
    return int'(bus.req_id[r*IW +: IW]);
  endfunction

  function automatic logic [NR-1:0] exp_gnt();
    logic [NR-1:0] g;
    g = '0;
    if (m_gr) g[m_sel] = 1'b1;
    return g;
  endfunction

  function automatic int exp_free();
    int c;
    c = 0;
    for (int u = 0; u < NU; u++) if (st[u] == 0) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < NU; u++) begin st[u] = 0; tbl[u] = 0; end
    for (int k = 0; k < (1 << IW); k++) cnt[k] = 0;
    m_rr = 0; m_gr = 0; m_sel = 0; m_uid = 0; m_err = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    int ru;
    bit rel_busy;
    int rel_id;
    bit done;
    int lf;
    ru       = int'(bus.rel_uid);
    rel_busy = bus.rel_valid && (st[ru] == 2);
    rel_id   = tbl[ru];
    if (!m_gr) begin
      lf = -1;
      for (int u = NU - 1; u >= 0; u--) if (st[u] == 0) lf = u;
      done = 0;
      if (lf >= 0) begin
        for (int k = 0; k < NR; k++) begin
          int r;
          bit ok;
          r  = (m_rr + k) % NR;
          ok = bus.req_valid[r];
`ifdef AR_UID_ID_LIMIT_EN
          if (cnt[req_id_of(r)] >= MPI) ok = 0;
`endif
          if (!done && ok) begin
            done = 1; m_gr = 1; m_sel = r; m_uid = lf; st[lf] = 1;
          end
        end
      end
    end else if (bus.req_ack[m_sel]) begin
      st[m_uid]  = 2;
      tbl[m_uid] = req_id_of(m_sel);
      cnt[tbl[m_uid]]++;
      m_rr = (m_sel + 1) % NR;
      m_gr = 0;
    end else if (!bus.req_valid[m_sel]) begin
      st[m_uid] = 0;
      m_gr = 0;
    end
    if (bus.rel_valid) begin
      if (rel_busy) begin st[ru] = 0; cnt[rel_id]--; end
      else m_err = 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0; bus.req_id = '0; bus.req_ack = '0;
    bus.rel_valid = 1'b0; bus.rel_uid = '0; bus.lookup_uid = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", bus.gnt); end
    checks++; if (bus.gnt_uid !== 4'd0) begin errors++; $display("FAIL reset_gnt_uid got %0d want 0", bus.gnt_uid); end
    checks++; if (bus.free_count !== 5'd16) begin errors++; $display("FAIL reset_free_count got %0d want 16", bus.free_count); end
    checks++; if (bus.err_rel !== 1'b0) begin errors++; $display("FAIL reset_err_rel got %b want 0", bus.err_rel); end
    checks++; if (bus.lookup_id !== 4'd0) begin errors++; $display("FAIL reset_lookup_id got %0d want 0", bus.lookup_id); end
    rst = 1'b1;
  endtask

  task automatic test_single_grant();
    bus.req_id[3:0] = 4'h3;
    bus.req_valid = 2'b01;
    tick();
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got %b want 01", bus.gnt); end
    checks++; if (bus.gnt_uid !== 4'd0) begin errors++; $display("FAIL single_uid got %0d want 0", bus.gnt_uid); end
    checks++; if (bus.free_count !== 5'd15) begin errors++; $display("FAIL single_free_reserved got %0d want 15", bus.free_count); end
    tick();
    checks++; if (bus.gnt !== 2'b01 || bus.gnt_uid !== 4'd0) begin errors++; $display("FAIL single_hold got %b/%0d want 01/0", bus.gnt, bus.gnt_uid); end
    bus.req_ack = 2'b01;
    tick();
    bus.req_ack = 2'b00;
    bus.req_valid = 2'b00;
    bus.lookup_uid = 4'd0;
    #1;
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL single_commit_gnt got %b want 00", bus.gnt); end
    checks++; if (bus.free_count !== 5'd15) begin errors++; $display("FAIL single_commit_free got %0d want 15", bus.free_count); end
    checks++; if (bus.lookup_id !== 4'h3) begin errors++; $display("FAIL single_lookup got %0d want 3", bus.lookup_id); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] eg;
    apply_reset();
    bus.req_id = {4'hA, 4'h3};
    bus.req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      tick();
      eg = (k % 2 != 0) ? 2'b00 : ((k % 4 == 0) ? 2'b01 : 2'b10);
      checks++; if (bus.gnt !== eg) begin errors++; $display("FAIL b2b_gnt cycle %0d got %b want %b", k, bus.gnt, eg); end
      if (k % 2 == 0) begin
        checks++; if (bus.gnt_uid !== 4'(k / 2)) begin errors++; $display("FAIL b2b_uid cycle %0d got %0d want %0d", k, bus.gnt_uid, k / 2); end
      end
      bus.req_ack = eg;
    end
    bus.req_valid = 2'b00;
    bus.req_ack = 2'b00;
    bus.lookup_uid = 4'd1;
    #1;
    checks++; if (bus.lookup_id !== 4'hA) begin errors++; $display("FAIL b2b_lookup got %0d want 10", bus.lookup_id); end
    checks++; if (bus.free_count !== 5'd12) begin errors++; $display("FAIL b2b_free got %0d want 12", bus.free_count); end
  endtask

  task automatic test_pool_exhaust();
    int n;
    n = 0;
    bus.req_id[3:0] = 4'd4;
    bus.req_valid = 2'b01;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (m_gr) bus.req_ack = 2'b01;
      else begin
        bus.req_ack = 2'b00;
        n++;
        bus.req_id[3:0] = 4'(4 + (n % 6));
      end
    end
    bus.req_id[3:0] = 4'd5;
    checks++; if (bus.free_count !== 5'd0) begin errors++; $display("FAIL exhaust_free got %0d want 0", bus.free_count); end
    repeat (2) begin
      tick();
      checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL exhaust_no_gnt got %b want 00", bus.gnt); end
    end
    bus.rel_valid = 1'b1;
    bus.rel_uid = 4'd5;
    tick();
    bus.rel_valid = 1'b0;
    checks++; if (bus.free_count !== 5'd1) begin errors++; $display("FAIL exhaust_rel_free got %0d want 1", bus.free_count); end
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL exhaust_rel_same_cycle got %b want 00", bus.gnt); end
    tick();
    checks++; if (bus.gnt !== 2'b01 || bus.gnt_uid !== 4'd5) begin errors++; $display("FAIL exhaust_regrant got %b/%0d want 01/5", bus.gnt, bus.gnt_uid); end
    checks++; if (bus.free_count !== 5'd0) begin errors++; $display("FAIL exhaust_regrant_free got %0d want 0", bus.free_count); end
    bus.req_valid = 2'b00;
    tick();
    checks++; if (bus.free_count !== 5'd1) begin errors++; $display("FAIL exhaust_abandon_free got %0d want 1", bus.free_count); end
  endtask

  task automatic test_abandon();
    apply_reset();
    bus.req_id = {4'h2, 4'h1};
    bus.req_valid = 2'b01;
    tick();
    bus.req_ack = 2'b01;
    tick();
    bus.req_ack = 2'b00;
    bus.req_valid = 2'b10;
    tick();
    checks++; if (bus.gnt !== 2'b10 || bus.gnt_uid !== 4'd1) begin errors++; $display("FAIL abandon_grant got %b/%0d want 10/1", bus.gnt, bus.gnt_uid); end
    checks++; if (bus.free_count !== 5'd14) begin errors++; $display("FAIL abandon_reserved_free got %0d want 14", bus.free_count); end
    bus.req_valid = 2'b00;
    tick();
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL abandon_drop_gnt got %b want 00", bus.gnt); end
    checks++; if (bus.free_count !== 5'd15) begin errors++; $display("FAIL abandon_restored_free got %0d want 15", bus.free_count); end
    bus.req_valid = 2'b11;
    tick();
    checks++; if (bus.gnt !== 2'b10 || bus.gnt_uid !== 4'd1) begin errors++; $display("FAIL abandon_rr_kept got %b/%0d want 10/1", bus.gnt, bus.gnt_uid); end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_err_rel();
    apply_reset();
    bus.rel_valid = 1'b1;
    bus.rel_uid = 4'd9;
    tick();
    bus.rel_valid = 1'b0;
    checks++; if (bus.err_rel !== 1'b1) begin errors++; $display("FAIL err_rel_set got %b want 1", bus.err_rel); end
    checks++; if (bus.free_count !== 5'd16) begin errors++; $display("FAIL err_rel_free got %0d want 16", bus.free_count); end
    repeat (3) tick();
    checks++; if (bus.err_rel !== 1'b1) begin errors++; $display("FAIL err_rel_sticky got %b want 1", bus.err_rel); end
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    bus.req_valid = 2'b01;
    tick();
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL midrst_pre_gnt got %b want 01", bus.gnt); end
    rst = 1'b0;
    #1;
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL midrst_gnt got %b want 00", bus.gnt); end
    checks++; if (bus.free_count !== 5'd16) begin errors++; $display("FAIL midrst_free got %0d want 16", bus.free_count); end
    apply_reset();
  endtask

`ifdef AR_UID_ID_LIMIT_EN
  task automatic test_id_limit();
    apply_reset();
    bus.req_id = {4'h2, 4'h7};
    bus.req_valid = 2'b01;
    repeat (2) begin
      tick();
      bus.req_ack = 2'b01;
      tick();
      bus.req_ack = 2'b00;
    end
    tick();
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL limit_block got %b want 00", bus.gnt); end
    bus.req_valid = 2'b11;
    tick();
    checks++; if (bus.gnt !== 2'b10 || bus.gnt_uid !== 4'd2) begin errors++; $display("FAIL limit_other_id got %b/%0d want 10/2", bus.gnt, bus.gnt_uid); end
    bus.req_ack = 2'b10;
    tick();
    bus.req_ack = 2'b00;
    bus.req_valid = 2'b01;
    bus.rel_valid = 1'b1;
    bus.rel_uid = 4'd0;
    tick();
    bus.rel_valid = 1'b0;
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL limit_rel_same_cycle got %b want 00", bus.gnt); end
    tick();
    checks++; if (bus.gnt !== 2'b01 || bus.gnt_uid !== 4'd0) begin errors++; $display("FAIL limit_regrant got %b/%0d want 01/0", bus.gnt, bus.gnt_uid); end
    bus.req_valid = 2'b00;
    tick();
  endtask
`endif

  task automatic test_random();
    int busy_q [$];
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (m_gr && m_sel == i) begin
          bus.req_valid[i] = ($urandom_range(0, 9) != 0);
          bus.req_ack[i]   = 1'($urandom_range(0, 1));
        end else begin
          bus.req_valid[i] = 1'($urandom_range(0, 1));
          bus.req_ack[i]   = ($urandom_range(0, 7) == 0);
`ifdef AR_UID_ID_LIMIT_EN
          bus.req_id[i*IW +: IW] = 4'($urandom_range(0, 3));
`else
          bus.req_id[i*IW +: IW] = 4'($urandom_range(0, 15));
`endif
        end
      end
      busy_q.delete();
      for (int u = 0; u < NU; u++) if (st[u] == 2) busy_q.push_back(u);
      bus.rel_valid = ($urandom_range(0, 2) == 0);
      if (busy_q.size() > 0 && $urandom_range(0, 3) != 0)
        bus.rel_uid = 4'(busy_q[$urandom_range(0, busy_q.size() - 1)]);
      else
        bus.rel_uid = 4'($urandom_range(0, 15));
      bus.lookup_uid = 4'($urandom_range(0, 15));
      tick();
      checks++; if (bus.gnt !== exp_gnt()) begin errors++; $display("FAIL rnd_gnt cycle %0d got %b want %b", cyc, bus.gnt, exp_gnt()); end
      if (m_gr) begin
        checks++; if (bus.gnt_uid !== 4'(m_uid)) begin errors++; $display("FAIL rnd_uid cycle %0d got %0d want %0d", cyc, bus.gnt_uid, m_uid); end
      end
      checks++; if (bus.free_count !== 5'(exp_free())) begin errors++; $display("FAIL rnd_free cycle %0d got %0d want %0d", cyc, bus.free_count, exp_free()); end
      checks++; if (bus.err_rel !== m_err) begin errors++; $display("FAIL rnd_err cycle %0d got %b want %b", cyc, bus.err_rel, m_err); end
      checks++; if (bus.lookup_id !== 4'(tbl[bus.lookup_uid])) begin errors++; $display("FAIL rnd_lookup cycle %0d got %0d want %0d", cyc, bus.lookup_id, tbl[bus.lookup_uid]); end
    end
    clear_inputs();
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    checks = 0;
    errors = 0;
    clear_inputs();
    test_reset();
    test_single_grant();
    test_back_to_back();
    test_pool_exhaust();
    test_abandon();
    test_err_rel();
    test_reset_mid_grant();
`ifdef AR_UID_ID_LIMIT_EN
    test_id_limit();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
